// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder driving one 4-bit carry-select slice, LSB nibble first
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, cin operand handshake;
//        out_valid/out_ready + sum, cout, ovf result handshake (result held stable while out_valid)
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             c_q;
    logic [IW-1:0]    idx;
    logic [3:0]       a_n, b_n;
    logic [4:0]       s0, s1, sl;
    logic             last;

    assign a_n  = a_q[{idx, 2'b00} +: 4];
    assign b_n  = b_q[{idx, 2'b00} +: 4];
    // carry-select slice: both carry-in cases computed, registered carry picks one
    assign s0   = {1'b0, a_n} + {1'b0, b_n};
    assign s1   = s0 + 5'd1;
    assign sl   = c_q ? s1 : s0;
    assign last = idx == IW'(N - 1);

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    c_q   <= cin;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= sl[3:0];
                    c_q <= sl[4];
                    idx <= idx + 1'b1;
                    if (last) begin
                        cout  <= sl[4];
                        ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sl[3] != a_q[WIDTH-1]);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder (WIDTH=16)
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          passed = 0;
    int          total = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // presents an operand bundle, checks accept and latency, then reads the result out
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        int cyc;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc, ho;
        int          cyc;
        // reset with random inputs
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("midcarry", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        // backpressure: hold result while a second bundle waits
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd4);
        hs = sum;
        hc = cout;
        ho = ovf;
        check("bp_sum", {16'd0, sum}, 32'h3334);
        in_valid = 1'b1;
        a = 16'h7FFF;
        b = 16'h0001;
        cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {14'd0, hc, ho, sum}, {14'd0, 1'b0, 1'b0, 16'h3334});
        end
        check("bp_hold_first", {14'd0, cout, ovf, sum}, {14'd0, hc, ho, hs});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        do_op("bp_second", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // reset at the second RUN edge aborts the operation
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h0101;
        cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) cyc++;
        end
        check("abort_no_pulse", 32'(cyc), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
